// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the timer_scheduler block.
// Optional feature macro used by the block: TIMER_SCHED_ABORT_EN.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N       = 26;
  localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester strictly
// after last_idx, wrapping modulo NUM_REQ.
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_idx,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  logic [IW-1:0] idx;

  // Scan from last_idx+1 around the ring; first asserted request wins.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_idx) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: NUM_REQ requesters share one N-bit interval counter.
// Round-robin grant, IDLE -> RUN -> DONE -> IDLE per interval.
// Optional: define TIMER_SCHED_ABORT_EN to let the owner abort its interval
// by dropping req during RUN (no done pulse in that case).
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*N-1:0] dur,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [N-1:0]         count
);

  localparam int            IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [N-1:0]         count_q, count_d;
  logic [N-1:0]         dur_q, dur_d;
  logic [IW-1:0]        last_q, last_d;

  logic [NUM_REQ-1:0]   pick;
  logic                 pick_vld;
  logic [N-1:0]         dur_sel;
  logic [IW-1:0]        grant_idx;
  logic                 abort;
  logic                 term;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .req      (req),
    .last_idx (last_q),
    .pick     (pick),
    .valid    (pick_vld)
  );

  // Mux out the duration slice of the requester about to be granted.
  always_comb begin
    dur_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) dur_sel = dur[i*N +: N];
    end
  end

  // Encode the one-hot grant into the index remembered as last-granted.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) grant_idx = IW'(i);
    end
  end

  // Interval end and (optional) owner abort conditions.
  always_comb begin
    term = (count_q == dur_q - N'(1));
`ifdef TIMER_SCHED_ABORT_EN
    abort = ~|(req & grant_q);
`else
    abort = 1'b0;
`endif
  end

  // Next-state logic; dur is sampled only on the grant edge.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    count_d = count_q;
    dur_d   = dur_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          count_d = '0;
          dur_d   = dur_sel;
          state_d = (dur_sel != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          last_d  = grant_idx;
        end else if (term) begin
          state_d = DONE;
          count_d = '0;
        end else begin
          count_d = count_q + N'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        last_d  = grant_idx;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      count_q <= '0;
      dur_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
      dur_q   <= dur_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign done  = (state_q == DONE) ? grant_q : '0;
  assign busy  = (state_q != IDLE);
  assign count = count_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler at N=8, NUM_REQ=4.
module tb_timer_scheduler;

  localparam int N  = 8;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*N-1:0] dur;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   done;
  logic            busy;
  logic [N-1:0]    count;

  int checks = 0;
  int errors = 0;

  timer_scheduler #(.N(N), .NUM_REQ(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .dur   (dur),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            rst;
    logic [NR-1:0]   rq;
    logic [NR*N-1:0] du;
    logic [NR-1:0]   g;
    logic [NR-1:0]   d;
    logic            b;
    logic [N-1:0]    c;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [NR-1:0] g, input logic [NR-1:0] d,
                            input logic b, input logic [N-1:0] c);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".done"},  32'(done),  32'(d));
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".count"}, 32'(count), 32'(c));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    dur   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // rst, req, dur {d3,d2,d1,d0}, exp grant, done, busy, count
    tbl[0]  = '{1'b1, 4'h0, 32'd0,  4'h0, 4'h0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 4'h1, 32'd5,  4'h1, 4'h0, 1'b1, 8'd0};
    tbl[2]  = '{1'b0, 4'h1, 32'd9,  4'h1, 4'h0, 1'b1, 8'd1};
    tbl[3]  = '{1'b0, 4'h1, 32'd9,  4'h1, 4'h0, 1'b1, 8'd2};
    tbl[4]  = '{1'b0, 4'h1, 32'd9,  4'h1, 4'h0, 1'b1, 8'd3};
    tbl[5]  = '{1'b0, 4'h1, 32'd9,  4'h1, 4'h0, 1'b1, 8'd4};
    tbl[6]  = '{1'b0, 4'h1, 32'd9,  4'h1, 4'h1, 1'b1, 8'd0};
    tbl[7]  = '{1'b0, 4'h0, 32'd0,  4'h0, 4'h0, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 4'h4, 32'd0,  4'h4, 4'h4, 1'b1, 8'd0};
    tbl[9]  = '{1'b0, 4'h0, 32'd0,  4'h0, 4'h0, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 4'h1, 32'd10, 4'h1, 4'h0, 1'b1, 8'd0};
    tbl[11] = '{1'b0, 4'h1, 32'd10, 4'h1, 4'h0, 1'b1, 8'd1};
    tbl[12] = '{1'b0, 4'h1, 32'd10, 4'h1, 4'h0, 1'b1, 8'd2};
    tbl[13] = '{1'b0, 4'h1, 32'd10, 4'h1, 4'h0, 1'b1, 8'd3};
    tbl[14] = '{1'b1, 4'h1, 32'd10, 4'h0, 4'h0, 1'b0, 8'd0};
    tbl[15] = '{1'b0, 4'h0, 32'd0,  4'h0, 4'h0, 1'b0, 8'd0};
    tbl[16] = '{1'b0, 4'ha, 32'd0,  4'h2, 4'h2, 1'b1, 8'd0};
    tbl[17] = '{1'b0, 4'h8, 32'd0,  4'h0, 4'h0, 1'b0, 8'd0};
    tbl[18] = '{1'b0, 4'h8, 32'd0,  4'h8, 4'h8, 1'b1, 8'd0};
    tbl[19] = '{1'b0, 4'h0, 32'd0,  4'h0, 4'h0, 1'b0, 8'd0};

    reset = 1'b1;
    req   = '0;
    dur   = '0;
    tick();

    // Table: single grant, dur change ignored, zero-duration, reset mid-run, rr order.
    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst;
      req   = tbl[i].rq;
      dur   = tbl[i].du;
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].d, tbl[i].b, tbl[i].c);
    end

    // All four requesting, dur=2: grants rotate 0,1,2,3,0 with one idle between.
    do_reset();
    req = 4'hf;
    dur = {8'd2, 8'd2, 8'd2, 8'd2};
    for (int k = 0; k < 5; k++) begin
      logic [NR-1:0] eg;
      eg = NR'(1 << (k % NR));
      tick();
      expect_out($sformatf("rr%0d.g", k), eg, 4'h0, 1'b1, 8'd0);
      tick();
      expect_out($sformatf("rr%0d.r", k), eg, 4'h0, 1'b1, 8'd1);
      tick();
      expect_out($sformatf("rr%0d.d", k), eg, eg, 1'b1, 8'd0);
      tick();
      expect_out($sformatf("rr%0d.i", k), 4'h0, 4'h0, 1'b0, 8'd0);
    end

    // Maximum duration: count reaches 254, then done, no wrap.
    do_reset();
    req = 4'h1;
    dur = {24'd0, 8'd255};
    tick();
    expect_out("max.g", 4'h1, 4'h0, 1'b1, 8'd0);
    for (int k = 1; k < 255; k++) tick();
    expect_out("max.top", 4'h1, 4'h0, 1'b1, 8'd254);
    tick();
    expect_out("max.done", 4'h1, 4'h1, 1'b1, 8'd0);
    req = 4'h0;
    tick();
    expect_out("max.idle", 4'h0, 4'h0, 1'b0, 8'd0);

    // Owner drops req at count=3 of dur=10.
    do_reset();
    req = 4'h1;
    dur = {24'd0, 8'd10};
    tick();
    tick();
    tick();
    tick();
    expect_out("drop.c3", 4'h1, 4'h0, 1'b1, 8'd3);
    req = 4'h0;
    tick();
`ifdef TIMER_SCHED_ABORT_EN
    expect_out("drop.abort", 4'h0, 4'h0, 1'b0, 8'd0);
`else
    expect_out("drop.c4", 4'h1, 4'h0, 1'b1, 8'd4);
    for (int k = 5; k < 10; k++) tick();
    expect_out("drop.c9", 4'h1, 4'h0, 1'b1, 8'd9);
    tick();
    expect_out("drop.done", 4'h1, 4'h1, 1'b1, 8'd0);
    tick();
    expect_out("drop.idle", 4'h0, 4'h0, 1'b0, 8'd0);
`endif
    // Last-granted is now 0, so requester 1 wins over 0.
    req = 4'h3;
    dur = {8'd0, 8'd0, 8'd0, 8'd0};
    tick();
    expect_out("drop.next", 4'h2, 4'h2, 1'b1, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
